uart_wb_param: RTL

- Parametrised successor to the current single-channel Wishbone UART.
- Adds:
  - configurable data length, parity and stop bits;
  - 16-bit baud divisor;
  - parametrised TX/RX FIFO depth;
  - start-bit glitch rejection;
  - status register with sticky parity, framing and overrun errors;
  - RX interrupt output.
- Sits on the SoC Wishbone bus as a peripheral slave.
- Drives the board's serial pins.

---
 rtl/uart_pkg.sv | 60 ++++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_wb_param.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encodings and parity helpers for uart_wb_param
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ADDR_TXDATA = 3'd0;
  localparam logic [2:0] ADDR_RXDATA = 3'd1;
  localparam logic [2:0] ADDR_DIV_LO = 3'd2;
  localparam logic [2:0] ADDR_DIV_HI = 3'd3;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;

  localparam int CTRL_LEN_LSB = 0;
  localparam int CTRL_PAR_LSB = 2;
  localparam int CTRL_STOP2   = 4;
  localparam int CTRL_RXIE    = 5;
  localparam int CTRL_TXIE    = 6;
  localparam int CTRL_ERRIE   = 7;

  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL  = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL  = 3;
  localparam int ST_PERR     = 4;
  localparam int ST_FERR     = 5;
  localparam int ST_OVR      = 6;
  localparam int ST_TX_BUSY  = 7;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_NONE2 = 2'b11;

  localparam logic [7:0] CTRL_RESET = 8'h03;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START_CHK, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  // Index of the last data bit for the configured length (5..8 bits)
  function automatic logic [2:0] last_bit_idx(input logic [7:0] ctrl);
    return {1'b0, ctrl[CTRL_LEN_LSB +: 2]} + 3'd4;
  endfunction

  function automatic logic parity_enabled(input logic [7:0] ctrl);
    return (ctrl[CTRL_PAR_LSB +: 2] == PAR_EVEN) || (ctrl[CTRL_PAR_LSB +: 2] == PAR_ODD);
  endfunction

  // Parity bit over the configured data bits only
  function automatic logic frame_parity(input logic [7:0] data, input logic [7:0] ctrl);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - ctrl[CTRL_LEN_LSB +: 2]);
    return (^(data & mask)) ^ (ctrl[CTRL_PAR_LSB +: 2] == PAR_ODD);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - first-word-fall-through synchronous FIFO, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign count    = count_q;
  assign data_out = mem_q[rd_ptr_q];

  // A push into a full FIFO is still accepted when a pop frees a slot the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers and occupancy; reset flushes contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: rtl/uart_wb_param.sv
// rtl/uart_wb_param.sv - Wishbone UART with configurable framing, baud divisor and FIFOs
module uart_wb_param
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 38,
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tx_bit,
  input  logic       rx_bit,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data_in,
  output logic [7:0] wb_data_out,
  input  logic       wb_we,
  input  logic       wb_stb,
  output logic       wb_ack,
  output logic       irq
);

  localparam int         CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

  logic          stb_seen_q, ack_q;
  logic [7:0]    rdata_q, rdata;
  logic          access, bus_wr, bus_rd;
  logic [15:0]   div_q;
  logic [7:0]    ctrl_q, status;
  logic          perr_q, ferr_q, ovr_q;
  logic          perr_set, ferr_set, ovr_set;
  logic [15:0]   baud_cnt_q, baud_cnt_d;
  logic          tick, div_wr;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]    tx_dout;
  logic [CW-1:0] tx_count;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]    rx_dout;
  logic [CW-1:0] rx_count;

  tx_state_e     tx_state_q, tx_state_d;
  logic [3:0]    tx_tcnt_q, tx_tcnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_shift_q, tx_shift_d, tx_ctrl_q, tx_ctrl_d;
  logic          tx_line_q, tx_line_d;

  rx_state_e     rx_state_q, rx_state_d;
  logic [3:0]    rx_tcnt_q, rx_tcnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_data_q, rx_data_d, rx_ctrl_q, rx_ctrl_d;
  logic          rx_par_bad_q, rx_par_bad_d;
  logic [1:0]    rx_sync_q;
  logic          rx_prev_q, rx_s;

  // One access per strobe assertion: act only on the first cycle stb is seen high
  assign access      = wb_stb & ~stb_seen_q;
  assign bus_wr      = access & wb_we;
  assign bus_rd      = access & ~wb_we;
  assign wb_ack      = ack_q;
  assign wb_data_out = rdata_q;
  assign tx_bit      = tx_line_q;
  assign div_wr      = bus_wr & ((wb_addr == ADDR_DIV_LO) | (wb_addr == ADDR_DIV_HI));

  assign tx_push = bus_wr & (wb_addr == ADDR_TXDATA);
  assign rx_pop  = bus_rd & (wb_addr == ADDR_RXDATA) & ~rx_empty;
  assign ovr_set = rx_push & rx_full & ~rx_pop;

  assign status = {tx_state_q != TX_IDLE, ovr_q, ferr_q, perr_q,
                   tx_full, tx_count == '0, rx_full, rx_count == '0};

  assign irq = (~rx_empty & ctrl_q[CTRL_RXIE]) | (tx_empty & ctrl_q[CTRL_TXIE]) |
               ((perr_q | ferr_q | ovr_q) & ctrl_q[CTRL_ERRIE]);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(reset), .push(tx_push), .pop(tx_pop), .data_in(wb_data_in),
    .data_out(tx_dout), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(reset), .push(rx_push), .pop(rx_pop), .data_in(rx_data_q),
    .data_out(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Register read mux
  always_comb begin
    rdata = '0;
    case (wb_addr)
      ADDR_RXDATA: rdata = rx_empty ? 8'h00 : rx_dout;
      ADDR_DIV_LO: rdata = div_q[7:0];
      ADDR_DIV_HI: rdata = div_q[15:8];
      ADDR_CTRL:   rdata = ctrl_q;
      ADDR_STATUS: rdata = status;
      default:     rdata = '0;
    endcase
  end

  // Bus handshake, config registers and sticky error flags (a new error beats a W1C)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stb_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      div_q      <= 16'(DEFAULT_DIV);
      ctrl_q     <= CTRL_RESET;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      stb_seen_q <= wb_stb;
      ack_q      <= access;
      if (bus_rd) rdata_q <= rdata;
      if (bus_wr && wb_addr == ADDR_DIV_LO) div_q[7:0]  <= wb_data_in;
      if (bus_wr && wb_addr == ADDR_DIV_HI) div_q[15:8] <= wb_data_in;
      if (bus_wr && wb_addr == ADDR_CTRL)   ctrl_q      <= wb_data_in;
      perr_q <= (perr_q & ~(bus_wr && wb_addr == ADDR_STATUS && wb_data_in[ST_PERR])) | perr_set;
      ferr_q <= (ferr_q & ~(bus_wr && wb_addr == ADDR_STATUS && wb_data_in[ST_FERR])) | ferr_set;
      ovr_q  <= (ovr_q  & ~(bus_wr && wb_addr == ADDR_STATUS && wb_data_in[ST_OVR]))  | ovr_set;
    end
  end

  // Baud generator: oversample tick every DIV+1 clocks, restarted by divisor writes
  assign tick = (baud_cnt_q == div_q);
  always_comb begin
    baud_cnt_d = baud_cnt_q + 16'd1;
    if (div_wr || tick) baud_cnt_d = '0;
  end

  // Baud counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) baud_cnt_q <= '0;
    else        baud_cnt_q <= baud_cnt_d;
  end

  // TX next-state: pop on entering START, CTRL frozen for the whole frame
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_ctrl_d  = tx_ctrl_q;
    tx_pop     = 1'b0;
    if (tx_state_q == TX_IDLE) begin
      if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_shift_d = tx_dout;
        tx_ctrl_d  = ctrl_q;
        tx_tcnt_d  = '0;
        tx_state_d = TX_START;
      end
    end else if (tick) begin
      if (tx_tcnt_q != TICK_LAST) begin
        tx_tcnt_d = tx_tcnt_q + 4'd1;
      end else begin
        tx_tcnt_d = '0;
        case (tx_state_q)
          TX_START: begin
            tx_idx_d   = '0;
            tx_state_d = TX_DATA;
          end
          TX_DATA: begin
            if (tx_idx_q == last_bit_idx(tx_ctrl_q))
              tx_state_d = parity_enabled(tx_ctrl_q) ? TX_PARITY : TX_STOP1;
            else
              tx_idx_d = tx_idx_q + 3'd1;
          end
          TX_PARITY: tx_state_d = TX_STOP1;
          TX_STOP1:  tx_state_d = tx_ctrl_q[CTRL_STOP2] ? TX_STOP2 : TX_IDLE;
          default:   tx_state_d = TX_IDLE;
        endcase
      end
    end
    case (tx_state_d)
      TX_START:  tx_line_d = 1'b0;
      TX_DATA:   tx_line_d = tx_shift_d[tx_idx_d];
      TX_PARITY: tx_line_d = frame_parity(tx_shift_d, tx_ctrl_d);
      default:   tx_line_d = 1'b1;
    endcase
  end

  // TX state register; line goes idle-high immediately on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_ctrl_q  <= CTRL_RESET;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_ctrl_q  <= tx_ctrl_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // Synchroniser resets low so a line held low through reset is not taken as a start edge
  assign rx_s = rx_sync_q[1];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_sync_q <= 2'b00;
      rx_prev_q <= 1'b0;
    end else begin
      rx_sync_q <= {rx_sync_q[0], rx_bit};
      rx_prev_q <= rx_s;
    end
  end

  // RX next-state: start re-checked mid-bit to reject glitches, then mid-bit sampling
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_tcnt_d    = rx_tcnt_q;
    rx_idx_d     = rx_idx_q;
    rx_data_d    = rx_data_q;
    rx_ctrl_d    = rx_ctrl_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_push      = 1'b0;
    perr_set     = 1'b0;
    ferr_set     = 1'b0;
    if (rx_state_q == RX_IDLE) begin
      if (rx_prev_q && !rx_s) begin
        rx_state_d   = RX_START_CHK;
        rx_tcnt_d    = '0;
        rx_idx_d     = '0;
        rx_data_d    = '0;
        rx_ctrl_d    = ctrl_q;
        rx_par_bad_d = 1'b0;
      end
    end else if (tick) begin
      if (rx_state_q == RX_START_CHK) begin
        if (rx_tcnt_q == TICK_MID) begin
          rx_tcnt_d  = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_tcnt_d = rx_tcnt_q + 4'd1;
        end
      end else if (rx_tcnt_q != TICK_LAST) begin
        rx_tcnt_d = rx_tcnt_q + 4'd1;
      end else begin
        rx_tcnt_d = '0;
        case (rx_state_q)
          RX_DATA: begin
            rx_data_d[rx_idx_q] = rx_s;
            if (rx_idx_q == last_bit_idx(rx_ctrl_q))
              rx_state_d = parity_enabled(rx_ctrl_q) ? RX_PARITY : RX_STOP;
            else
              rx_idx_d = rx_idx_q + 3'd1;
          end
          RX_PARITY: begin
            rx_par_bad_d = (rx_s != frame_parity(rx_data_q, rx_ctrl_q));
            rx_state_d   = RX_STOP;
          end
          RX_STOP: begin
            rx_push    = 1'b1;
            perr_set   = rx_par_bad_q;
            ferr_set   = ~rx_s;
            rx_state_d = RX_IDLE;
          end
          default: rx_state_d = RX_IDLE;
        endcase
      end
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state_q   <= RX_IDLE;
      rx_tcnt_q    <= '0;
      rx_idx_q     <= '0;
      rx_data_q    <= '0;
      rx_ctrl_q    <= CTRL_RESET;
      rx_par_bad_q <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_tcnt_q    <= rx_tcnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_data_q    <= rx_data_d;
      rx_ctrl_q    <= rx_ctrl_d;
      rx_par_bad_q <= rx_par_bad_d;
    end
  end

endmodule
